// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multi-digit seven-segment scan controller with frame-boundary updates.
// Define SEG_SCAN_BLINK_EN to enable per-digit blinking.
module seg_scan_ctrl #(
    parameter int NUM_DIG = 4,
    parameter int DIV = 50000,
    parameter int BLANK = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [4*NUM_DIG-1:0]   data_in,
    input  logic [NUM_DIG-1:0]     dig_en,
    input  logic [NUM_DIG-1:0]     blink_mask,
    output logic                   pend,
    output logic                   frame_start,
    output logic [3:0]             hex_out,
    output logic                   hex_en,
    output logic [NUM_DIG-1:0]     an_n
);
    localparam int CW = $clog2(DIV + 1);
    localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIG - 1);
    localparam logic [CW-1:0] BLANK_END = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [CW-1:0] SHOW_END = CW'(DIV - BLANK - 1);
    typedef enum logic {S_BLANK, S_SHOW} state_t;
    localparam state_t S_INIT = (BLANK == 0) ? S_SHOW : S_BLANK;
    state_t st, st_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [NUM_DIG-1:0][3:0] act_data, pend_data, act_data_nx;
    logic [NUM_DIG-1:0] act_en, pend_en, act_en_nx, hide, an_d;
    logic [3:0] hex_d;
    logic bnd, show;
    // The boundary is the first cycle of slot 0; outputs produced at this edge describe it.
    assign bnd = (idx == '0) && (cnt == '0) && (st == S_INIT);
    assign act_data_nx = (bnd && load) ? data_in : (bnd && pend) ? pend_data : act_data;
    assign act_en_nx = (bnd && load) ? dig_en : (bnd && pend) ? pend_en : act_en;
`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    logic [FW-1:0] fcnt;
    logic phase, phase_nx, wrap_f;
    logic [NUM_DIG-1:0] act_bm, pend_bm, act_bm_nx;
    assign wrap_f = bnd && (fcnt == FW'(BLINK_FRAMES));
    assign phase_nx = phase ^ wrap_f;
    assign act_bm_nx = (bnd && load) ? blink_mask : (bnd && pend) ? pend_bm : act_bm;
    assign hide = phase_nx ? act_bm_nx : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
            phase <= 1'b0;
            act_bm <= '0;
            pend_bm <= '0;
        end else begin
            fcnt <= !bnd ? fcnt : wrap_f ? FW'(1) : fcnt + 1'b1;
            phase <= phase_nx;
            act_bm <= act_bm_nx;
            if (load) pend_bm <= blink_mask;
        end
    end
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign hide = '0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= S_INIT;
            cnt <= '0;
            idx <= '0;
        end else begin
            st <= st_nx;
            cnt <= cnt_nx;
            idx <= idx_nx;
        end
    end
    always_comb begin
        st_nx = st;
        cnt_nx = cnt + 1'b1;
        idx_nx = idx;
        if (st == S_BLANK && cnt == BLANK_END) begin
            st_nx = S_SHOW;
            cnt_nx = '0;
        end else if (st == S_SHOW && cnt == SHOW_END) begin
            st_nx = S_INIT;
            cnt_nx = '0;
            idx_nx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end
    always_comb begin
        show = (st == S_SHOW) && act_en_nx[idx] && !hide[idx];
        an_d = show ? ~(NUM_DIG'(1) << idx) : '1;
        hex_d = show ? act_data_nx[idx] : 4'h0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data <= '0;
            act_en <= '0;
            pend_data <= '0;
            pend_en <= '0;
            pend <= 1'b0;
            frame_start <= 1'b0;
            hex_out <= 4'h0;
            hex_en <= 1'b0;
            an_n <= '1;
        end else begin
            act_data <= act_data_nx;
            act_en <= act_en_nx;
            pend <= !bnd && (load || pend);
            if (load) begin
                pend_data <= data_in;
                pend_en <= dig_en;
            end
            frame_start <= bnd;
            hex_out <= hex_d;
            hex_en <= show;
            an_n <= an_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed checks of seg_scan_ctrl against a frame-level model.
// Honours SEG_SCAN_BLINK_EN the same way the design does.
module tb_seg_scan_ctrl;
    localparam int ND = 4, DV = 8, BL = 2, BF = 2, FP = ND * DV;
    logic clk = 1'b0, rst_n = 1'b0, load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0] dig_en = '0, blink_mask = '0;
    logic pend, frame_start, hex_en;
    logic [3:0] hex_out, an_n;
    int checks = 0, errors = 0, mt = -1;
    logic [15:0] m_ad, m_pd;
    logic [3:0] m_ae, m_pe, m_ab, m_pb;
    logic m_pend;

    seg_scan_ctrl #(.NUM_DIG(ND), .DIV(DV), .BLANK(BL), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dig_en(dig_en),
        .blink_mask(blink_mask), .pend(pend), .frame_start(frame_start),
        .hex_out(hex_out), .hex_en(hex_en), .an_n(an_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, mt, got, exp);
        end
    endtask

    task automatic compare();
        int slot, off, ph;
        logic vis;
        logic [3:0] an_exp;
        slot = (mt % FP) / DV;
        off = mt % DV;
`ifdef SEG_SCAN_BLINK_EN
        ph = ((mt / FP) / BF) % 2;
`else
        ph = 0;
`endif
        vis = off >= BL && m_ae[slot] && !(ph == 1 && m_ab[slot]);
        an_exp = vis ? ~(4'b0001 << slot) : 4'hF;
        check("an_n", {12'h0, an_n}, {12'h0, an_exp});
        check("hex_en", {15'h0, hex_en}, {15'h0, vis});
        if (vis) check("hex_out", {12'h0, hex_out}, {12'h0, m_ad[slot*4 +: 4]});
        check("frame_start", {15'h0, frame_start}, {15'h0, mt % FP == 0});
        check("pend", {15'h0, pend}, {15'h0, m_pend});
    endtask

    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] e, input logic [3:0] b);
        load = ld;
        data_in = d;
        dig_en = e;
        blink_mask = b;
        @(posedge clk);
        mt++;
        if (mt % FP == 0) begin
            if (ld) begin
                m_ad = d; m_ae = e; m_ab = b;
            end else if (m_pend) begin
                m_ad = m_pd; m_ae = m_pe; m_ab = m_pb;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_pd = d; m_pe = e; m_pb = b; m_pend = 1'b1;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic wait_bnd();
        for (int i = 0; i < FP && (mt + 1) % FP != 0; i++) idle(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load = 1'b0;
        #1;
        check("rst_an_n", {12'h0, an_n}, 16'h000F);
        check("rst_hex_en", {15'h0, hex_en}, 16'h0);
        check("rst_pend", {15'h0, pend}, 16'h0);
        check("rst_frame_start", {15'h0, frame_start}, 16'h0);
        check("rst_hex_out", {12'h0, hex_out}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mt = -1;
        m_ad = '0; m_pd = '0; m_ae = '0; m_pe = '0; m_ab = '0; m_pb = '0; m_pend = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        idle(1);
        step(1'b1, 16'h4321, 4'hF, 4'h0);
        idle(2 * FP);
        step(1'b1, 16'h8765, 4'b0101, 4'h0);
        idle(2 * FP);
        wait_bnd();
        idle(3);
        step(1'b1, 16'h1111, 4'hF, 4'h0);
        idle(3);
        step(1'b1, 16'h2222, 4'hF, 4'h0);
        idle(2 * FP);
        wait_bnd();
        idle(5);
        step(1'b1, 16'h1111, 4'hF, 4'h0);
        wait_bnd();
        step(1'b1, 16'h5555, 4'hF, 4'h0);
        idle(FP);
        for (int i = 0; i < FP && !((mt % FP) / DV == 2 && mt % DV == 4); i++) idle(1);
        do_reset();
        step(1'b1, 16'h9876, 4'hF, 4'b0001);
        idle(6 * FP);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
